// File: rtl/overdrive_pkg.sv
// Shared types and arithmetic helpers for the overdrive stream datapath.
// All helpers work on a 64-bit signed working width wide enough for every stage.
package overdrive_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_HARD   = 2'b01,
        MODE_SOFT   = 2'b10,
        MODE_ASYM   = 2'b11
    } mode_e;

    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t thresh_t(input int bits);
        return (calc_t'(64'sd1) <<< bits) - calc_t'(64'sd1);
    endfunction

    function automatic calc_t thresh_h(input int bits);
        return thresh_t(bits) >>> 1;
    endfunction

    // Round half up, then arithmetic shift out the fractional bits.
    function automatic calc_t round_shift(input calc_t p, input int frac);
        calc_t r;
        if (frac > 0) begin
            r = (p + (calc_t'(64'sd1) <<< (frac - 1))) >>> frac;
        end else begin
            r = p;
        end
        return r;
    endfunction

    function automatic calc_t sat_signed(input calc_t v, input int w);
        calc_t hi;
        calc_t lo;
        calc_t r;
        hi = (calc_t'(64'sd1) <<< (w - 1)) - calc_t'(64'sd1);
        lo = -(calc_t'(64'sd1) <<< (w - 1));
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic calc_t abs_val(input calc_t v);
        calc_t r;
        if (v < calc_t'(64'sd0)) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/drive_shaper.sv
// Combinational waveshaper: maps the scaled sample v to y for the selected mode
// and flags whether the output magnitude was altered.
module drive_shaper
    import overdrive_pkg::*;
#(
    parameter int V_W             = 29,
    parameter int OUT_W           = 32,
    parameter int CLIP_LEVEL_BITS = 12
) (
    input  logic signed [V_W-1:0]   v,
    input  mode_e                   mode,
    output logic signed [OUT_W-1:0] y,
    output logic                    clipped
);

    localparam calc_t T_LVL    = thresh_t(CLIP_LEVEL_BITS);
    localparam calc_t H_LVL    = thresh_h(CLIP_LEVEL_BITS);
    localparam calc_t KNEE_END = calc_t'(64'sd3) * H_LVL + calc_t'(64'sd1);

    calc_t v_ext_s;
    calc_t mag_v_s;
    calc_t mag_y_s;
    calc_t y_ext_s;

    // Shape the sample and compare magnitudes to detect clipping.
    always_comb begin
        v_ext_s = calc_t'(v);
        mag_v_s = abs_val(v_ext_s);
        mag_y_s = calc_t'(64'sd0);
        y_ext_s = v_ext_s;
        case (mode)
            MODE_BYPASS: begin
                y_ext_s = sat_signed(v_ext_s, OUT_W);
            end
            MODE_HARD: begin
                if (v_ext_s > T_LVL) begin
                    y_ext_s = T_LVL;
                end else if (v_ext_s < -T_LVL) begin
                    y_ext_s = -T_LVL;
                end else begin
                    y_ext_s = v_ext_s;
                end
            end
            MODE_SOFT: begin
                // Slope halves above the knee so both segments meet at H.
                if (mag_v_s <= H_LVL) begin
                    mag_y_s = mag_v_s;
                end else if (mag_v_s < KNEE_END) begin
                    mag_y_s = H_LVL + ((mag_v_s - H_LVL) >>> 1);
                end else begin
                    mag_y_s = T_LVL;
                end
                if (v_ext_s < calc_t'(64'sd0)) begin
                    y_ext_s = -mag_y_s;
                end else begin
                    y_ext_s = mag_y_s;
                end
            end
            MODE_ASYM: begin
                if (v_ext_s > T_LVL) begin
                    y_ext_s = T_LVL;
                end else if (v_ext_s < -H_LVL) begin
                    y_ext_s = -H_LVL;
                end else begin
                    y_ext_s = v_ext_s;
                end
            end
            default: begin
                y_ext_s = v_ext_s;
            end
        endcase
        clipped = (abs_val(y_ext_s) != mag_v_s);
        y       = y_ext_s[OUT_W-1:0];
    end

endmodule

// File: rtl/overdrive_stream.sv
// Three-stage overdrive: slew-limited gain, rounded scaling, waveshaping,
// plus a saturating count of clipped output samples.
module overdrive_stream
    import overdrive_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int GAIN_W          = 16,
    parameter int GAIN_FRAC       = 4,
    parameter int OUT_W           = 32,
    parameter int CLIP_LEVEL_BITS = 12,
    parameter int GAIN_STEP       = 4,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] signal_in,
    input  logic [GAIN_W-1:0]        gain,
    input  logic [1:0]               mode,
    input  logic                     clip_clr,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  signal_out,
    output logic [CNT_W-1:0]         clip_count
);

    localparam int P_W = DATA_W + GAIN_W + 1;
    localparam int V_W = P_W - GAIN_FRAC;
    localparam logic [GAIN_W-1:0] STEP    = GAIN_W'(GAIN_STEP);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic [GAIN_W-1:0]        g_r;
    logic [GAIN_W-1:0]        g_next_s;
    logic signed [DATA_W-1:0] x1_r;
    mode_e                    mode1_r;
    logic                     vld1_r;
    logic signed [P_W-1:0]    x_ext_s;
    logic signed [P_W-1:0]    g_ext_s;
    logic signed [P_W-1:0]    p_s;
    logic signed [V_W-1:0]    v_s;
    logic signed [V_W-1:0]    v2_r;
    mode_e                    mode2_r;
    logic                     vld2_r;
    logic signed [OUT_W-1:0]  y_s;
    logic                     clipped_s;

    // Move the applied gain toward the target by at most STEP per accepted sample.
    always_comb begin
        g_next_s = g_r;
        if (gain > g_r) begin
            if ((gain - g_r) > STEP) begin
                g_next_s = g_r + STEP;
            end else begin
                g_next_s = gain;
            end
        end else if (gain < g_r) begin
            if ((g_r - gain) > STEP) begin
                g_next_s = g_r - STEP;
            end else begin
                g_next_s = gain;
            end
        end else begin
            g_next_s = g_r;
        end
    end

    assign x_ext_s = P_W'(x1_r);
    assign g_ext_s = P_W'({1'b0, g_r});
    assign p_s     = x_ext_s * g_ext_s;
    assign v_s     = V_W'(round_shift(calc_t'(p_s), GAIN_FRAC));

    drive_shaper #(
        .V_W             (V_W),
        .OUT_W           (OUT_W),
        .CLIP_LEVEL_BITS (CLIP_LEVEL_BITS)
    ) u_shaper (
        .v       (v2_r),
        .mode    (mode2_r),
        .y       (y_s),
        .clipped (clipped_s)
    );

    // Pipeline registers; the gain ramp only advances on accepted samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            g_r        <= '0;
            x1_r       <= '0;
            mode1_r    <= MODE_BYPASS;
            vld1_r     <= 1'b0;
            v2_r       <= '0;
            mode2_r    <= MODE_BYPASS;
            vld2_r     <= 1'b0;
            out_valid  <= 1'b0;
            signal_out <= '0;
        end else begin
            vld1_r <= in_valid;
            if (in_valid) begin
                x1_r    <= signal_in;
                mode1_r <= mode_e'(mode);
                g_r     <= g_next_s;
            end
            vld2_r <= vld1_r;
            if (vld1_r) begin
                v2_r    <= v_s;
                mode2_r <= mode1_r;
            end
            out_valid <= vld2_r;
            if (vld2_r) begin
                signal_out <= y_s;
            end
        end
    end

    // Saturating clip counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clip_count <= '0;
        end else if (clip_clr) begin
            clip_count <= '0;
        end else if (vld2_r && clipped_s && (clip_count != CNT_MAX)) begin
            clip_count <= clip_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            clip_count <= clip_count;
        end
    end

endmodule

// File: tb/tb_overdrive_stream.sv
// Directed bench for overdrive_stream with hand-computed expectations; a second
// instance with a 4-bit counter exercises counter saturation.
module tb_overdrive_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] signal_in;
    logic [15:0]        gain;
    logic [1:0]         mode;
    logic               clip_clr;
    logic               out_valid;
    logic signed [31:0] signal_out;
    logic [15:0]        clip_count;
    logic               out_valid4;
    logic signed [31:0] signal_out4;
    logic [3:0]         clip_count4;

    int     checks = 0;
    int     errors = 0;
    longint exp_cnt = 0;

    always #5 clk = ~clk;

    overdrive_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signal_in(signal_in),
        .gain(gain), .mode(mode), .clip_clr(clip_clr), .out_valid(out_valid),
        .signal_out(signal_out), .clip_count(clip_count)
    );

    overdrive_stream #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signal_in(signal_in),
        .gain(gain), .mode(mode), .clip_clr(clip_clr), .out_valid(out_valid4),
        .signal_out(signal_out4), .clip_count(clip_count4)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int m, input int gn);
        signal_in = 16'(x);
        mode      = 2'(m);
        gain      = 16'(gn);
    endtask

    // One isolated sample: checks exact 3-cycle latency, value and clip count.
    task automatic send_check(input string tag, input int x, input int m, input int gn,
                              input longint exp_y, input int exp_clip);
        drive(x, m, gn);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk(tag, signal_out, exp_y);
        exp_cnt += exp_clip;
        chk({tag, "_cnt"}, clip_count, exp_cnt);
    endtask

    // Stream unchecked samples to move the gain ramp, then drain the pipe.
    task automatic settle(input int x, input int m, input int gn, input int n);
        drive(x, m, gn);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; clip_clr = 1'b0;
        drive(0, 0, 0);
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_out", signal_out, 0);
        chk("rst_cnt", clip_count, 0);
        chk("rst_cnt4", clip_count4, 0);
        rst = 1'b1;

        // Gain ramp from 0 to 32 in steps of 4.
        drive(1000, 1, 32);
        in_valid = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 2) chk("ramp_early", out_valid, 0);
            if (k >= 3) begin
                chk("ramp_valid", out_valid, 1);
                chk($sformatf("ramp_%0d", k - 3), signal_out, 250 * ((k - 2) < 8 ? (k - 2) : 8));
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("ramp_cnt", clip_count, 0);

        send_check("hard_pos", 4000, 1, 32, 4095, 1);
        send_check("hard_neg", -4000, 1, 32, -4095, 1);

        settle(0, 2, 16, 4);
        send_check("soft_pos", 3000, 2, 16, 2523, 1);
        send_check("soft_neg", -3000, 2, 16, -2523, 1);
        send_check("soft_lin", 2000, 2, 16, 2000, 0);
        send_check("soft_top", 8000, 2, 16, 4095, 1);

        send_check("asym_neg", -3000, 3, 16, -2047, 1);
        send_check("asym_pos", 3000, 3, 16, 3000, 0);

        settle(0, 0, 65535, 16380);
        send_check("bypass_max", -32768, 0, 65535, -134215680, 0);

        // Clear coincides with a clipped sample entering the output register.
        drive(4000, 1, 65535);
        in_valid = 1'b1;
        tick(); tick(); tick();
        chk("clr_pre_valid", out_valid, 1);
        clip_clr = 1'b1;
        tick();
        clip_clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", clip_count, 0);
        chk("clr_cnt4", clip_count4, 0);
        tick(); tick(); tick();
        exp_cnt = 2;
        chk("clr_after", clip_count, exp_cnt);

        settle(4000, 1, 65535, 20);
        exp_cnt += 20;
        chk("sat_cnt4", clip_count4, 15);
        chk("sat_cnt16", clip_count, exp_cnt);

        // Reset with two samples in flight discards them and restarts the ramp.
        drive(1000, 1, 32);
        in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst2_out", signal_out, 0);
        chk("rst2_cnt", clip_count, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rst2_valid", out_valid, 0);
            tick();
        end
        exp_cnt = 0;
        send_check("rst2_ramp", 1000, 1, 32, 250, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
